// File: rtl/tile_stream_packer_pkg.sv
// tile_stream_pkg: shared FSM state, default geometry and counter-width helper for tile_stream_packer
package tile_stream_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int TILE_W_DEF = 28;
  localparam int TDATA_W = 32;
  localparam int TILE_BYTES = TILE_W_DEF * 28;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tile_stream_packer_sync_fifo.sv
// sync_fifo: FIFO with registered output stage; DEPTH counts the output register
module sync_fifo
  import tile_stream_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = cnt_w(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] mcnt;
  logic ov, rd, load, wr;
  assign empty = ~ov;
  assign rd = pop & ov;
  assign full = (mcnt + (AW+1)'(ov)) == (AW+1)'(DEPTH);
  assign load = (mcnt != '0) & (~ov | pop);
  assign wr = push & (~full | rd);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      mcnt <= '0;
      ov <= 1'b0;
      dout <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (load) begin
        dout <= mem[rp];
        rp <= rp + 1'b1;
      end
      ov <= load | (ov & ~pop);
      mcnt <= mcnt + (AW+1)'(wr) - (AW+1)'(load);
    end
endmodule

// File: rtl/tile_stream_packer.sv
// tile_stream_packer: packs pixel bytes into AXIS words with per-tile tlast; TILE_STREAM_PACKER_TUSER_EN adds m_axis_tuser
module tile_stream_packer
  import tile_stream_pkg::*;
#(
  parameter int BYTES_PER_WORD = TDATA_W / 8,
  parameter int TILE_W = TILE_W_DEF,
  parameter int TILE_H = TILE_BYTES / TILE_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic [7:0]                  pix_data,
  input  logic                        pix_valid,
  input  logic                        pix_sot,
  input  logic                        err_clr,
  output logic [8*BYTES_PER_WORD-1:0] m_axis_tdata,
  output logic [BYTES_PER_WORD-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
`ifdef TILE_STREAM_PACKER_TUSER_EN
  output logic                        m_axis_tuser,
`endif
  output logic                        overflow,
  output logic                        resync_err,
  output logic [15:0]                 tile_count
);
  localparam int DW = 8 * BYTES_PER_WORD;
  localparam int TB = TILE_W * TILE_H;
  localparam int LW = cnt_w(BYTES_PER_WORD);
  localparam int BW = cnt_w(TB);
`ifdef TILE_STREAM_PACKER_TUSER_EN
  localparam int FW = DW + BYTES_PER_WORD + 2;
`else
  localparam int FW = DW + BYTES_PER_WORD + 1;
`endif
  localparam logic [LW-1:0] LAST_LANE = LW'(BYTES_PER_WORD - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(TB - 1);
  localparam logic [BYTES_PER_WORD-1:0] KEEP_ALL = '1;
  state_t state;
  logic [LW-1:0] lane, cur_lane;
  logic [BW-1:0] bcnt, cur_b;
  logic [DW-1:0] word, wdata;
  logic [BYTES_PER_WORD-1:0] keep;
  logic [FW-1:0] din, dout;
  logic start, take, last, done, full, empty, ovf;
  assign start = pix_valid & pix_sot;
  assign take = pix_valid & (pix_sot | (state == ACTIVE));
  assign cur_lane = start ? '0 : lane;
  assign cur_b = start ? '0 : bcnt;
  assign last = cur_b == LAST_BYTE;
  assign done = take & ((cur_lane == LAST_LANE) | last);
  assign keep = KEEP_ALL >> (LAST_LANE - cur_lane);
  assign ovf = done & full & ~(m_axis_tvalid & m_axis_tready);
  assign m_axis_tvalid = ~empty;
  always_comb begin
    wdata = start ? '0 : word;
    wdata[cur_lane*8 +: 8] = pix_data;
  end
`ifdef TILE_STREAM_PACKER_TUSER_EN
  logic first;
  assign din = {start | first, last, keep, wdata};
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = dout;
  always_ff @(posedge aclk)
    if (reset) first <= 1'b0;
    else if (take) first <= ~done & (start | first);
`else
  assign din = {last, keep, wdata};
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = dout;
`endif
  // a sot while ACTIVE means the previous tile was cut short
  always_ff @(posedge aclk)
    if (reset) begin
      state <= IDLE;
      lane <= '0;
      bcnt <= '0;
      word <= '0;
      tile_count <= '0;
      overflow <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      if (take) begin
        state <= last ? IDLE : ACTIVE;
        lane <= done ? '0 : cur_lane + 1'b1;
        bcnt <= last ? '0 : cur_b + 1'b1;
        word <= done ? '0 : wdata;
      end
      if (take & last) tile_count <= tile_count + 1'b1;
      overflow <= ovf | (overflow & ~err_clr);
      resync_err <= (start & (state == ACTIVE)) | (resync_err & ~err_clr);
    end
  sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(aclk),
    .rst(reset),
    .push(done),
    .din(din),
    .pop(m_axis_tready),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_tile_stream_packer.sv
// tb_tile_stream_packer: queue-based reference model plus directed tile, back-pressure, resync, reset and partial-word vectors
module tb_tile_stream_packer;
  import tile_stream_pkg::*;
  localparam int BPW = TDATA_W / 8;
  localparam int TB = TILE_BYTES;
  localparam int DEPTH = 8;
  logic aclk = 0, reset = 1, pix_valid = 0, pix_sot = 0, err_clr = 0, tready = 0;
  logic [7:0] pix_data = 0;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic tlast, tvalid, overflow, resync_err;
  logic [15:0] tile_count;
  logic p1_valid = 0, p1_sot = 0;
  logic [7:0] p1_data = 0;
  logic [31:0] t1data;
  logic [3:0] t1keep;
  logic t1last, t1valid, t1ovf, t1rs;
  logic [15:0] t1cnt;
`ifdef TILE_STREAM_PACKER_TUSER_EN
  logic tuser, t1user;
`endif
  always #5 aclk = ~aclk;

  tile_stream_packer u0 (
`ifdef TILE_STREAM_PACKER_TUSER_EN
    .m_axis_tuser(tuser),
`endif
    .aclk(aclk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid), .pix_sot(pix_sot),
    .err_clr(err_clr), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .overflow(overflow), .resync_err(resync_err),
    .tile_count(tile_count)
  );

  tile_stream_packer #(.TILE_W(3), .TILE_H(3)) u1 (
`ifdef TILE_STREAM_PACKER_TUSER_EN
    .m_axis_tuser(t1user),
`endif
    .aclk(aclk), .reset(reset), .pix_data(p1_data), .pix_valid(p1_valid), .pix_sot(p1_sot),
    .err_clr(1'b0), .m_axis_tdata(t1data), .m_axis_tkeep(t1keep), .m_axis_tlast(t1last),
    .m_axis_tvalid(t1valid), .m_axis_tready(1'b1), .overflow(t1ovf), .resync_err(t1rs),
    .tile_count(t1cnt)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: byte list per word, word queue standing for the whole FIFO
  typedef struct {logic [31:0] d; logic [3:0] k; logic l; logic u; int t;} wd_t;
  wd_t q[$];
  logic [7:0] cur[$];
  int idx = 0, cyc = 0;
  bit act = 0, first = 0, m_valid = 0, chk_en = 0;
  logic m_ovf = 0, m_rs = 0;
  logic [15:0] m_tiles = 0;

  always @(posedge aclk) begin : model
    wd_t w;
    bit oe, re;
    if (reset) begin
      q.delete(); cur.delete();
      idx = 0; act = 0; first = 0; m_valid = 0; m_ovf = 0; m_rs = 0; m_tiles = 0;
    end else begin
      oe = 0; re = 0;
      if (m_valid && tready) void'(q.pop_front());
      if (pix_valid) begin
        if (pix_sot) begin
          re = act; cur.delete(); idx = 0; act = 1; first = 1;
        end
        if (act) begin
          cur.push_back(pix_data);
          idx++;
          if (cur.size() == BPW || idx == TB) begin
            w.d = 0;
            foreach (cur[i]) w.d |= 32'(cur[i]) << (8 * i);
            w.k = 4'((1 << cur.size()) - 1);
            w.l = (idx == TB);
            w.u = first;
            w.t = cyc;
            if (q.size() >= DEPTH) oe = 1;
            else q.push_back(w);
            cur.delete();
            first = 0;
            if (idx == TB) begin
              act = 0; m_tiles++;
            end
          end
        end
      end
      m_ovf = oe | (m_ovf & ~err_clr);
      m_rs = re | (m_rs & ~err_clr);
      m_valid = q.size() > 0 && q[0].t < cyc;
    end
    cyc++;
  end

  always @(negedge aclk) if (chk_en) begin
    chk("tvalid", tvalid, m_valid);
    if (m_valid) begin
      chk("tdata", tdata, q[0].d);
      chk("tkeep", tkeep, q[0].k);
      chk("tlast", tlast, q[0].l);
`ifdef TILE_STREAM_PACKER_TUSER_EN
      chk("tuser", tuser, q[0].u);
`endif
    end
    chk("overflow", overflow, m_ovf);
    chk("resync_err", resync_err, m_rs);
    chk("tile_count", tile_count, m_tiles);
  end

  int nw = 0, nlast = 0, last_idx = 0, nbad = 0;
  logic [31:0] first_d = 0, last_d = 0;
  int uidx[$];
  logic [36:0] q1[$];
  always @(negedge aclk) begin
    if (tvalid && tready) begin
      nw++;
      if (nw == 1) first_d = tdata;
      last_d = tdata;
      if (tkeep != 4'hF) nbad++;
      if (tlast) begin
        nlast++; last_idx = nw;
      end
`ifdef TILE_STREAM_PACKER_TUSER_EN
      if (tuser) uidx.push_back(nw);
`endif
    end
    if (t1valid) q1.push_back({t1last, t1keep, t1data});
  end

  task automatic clear();
    nw = 0; nlast = 0; last_idx = 0; nbad = 0; uidx.delete();
  endtask
  task automatic tick();
    @(posedge aclk);
    #1;
    pix_valid = 0; pix_sot = 0; err_clr = 0; p1_valid = 0; p1_sot = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic send(input logic [7:0] d, input logic s);
    pix_data = d; pix_valid = 1; pix_sot = s;
    tick();
  endtask
  task automatic send1(input logic [7:0] d, input logic s);
    p1_data = d; p1_valid = 1; p1_sot = s;
    tick();
  endtask

  initial begin
    idle(3);
    chk_en = 1;
    chk("rst tvalid", tvalid, 0);
    chk("rst tdata", tdata, 0);
    chk("rst tkeep", tkeep, 0);
    chk("rst tile_count", tile_count, 0);
    chk("rst overflow", overflow, 0);
    reset = 0;
    tready = 1;
    // one full tile, no back-pressure
    clear();
    for (int i = 0; i < TB; i++) send(8'(i), i == 0);
    idle(6);
    chk("t1 words", 64'(nw), 196);
    chk("t1 first word", first_d, 32'h03020100);
    chk("t1 tlast count", 64'(nlast), 1);
    chk("t1 tlast position", 64'(last_idx), 196);
    chk("t1 bad tkeep", 64'(nbad), 0);
    chk("t1 tile_count", tile_count, 1);
    // back-pressure: FIFO fills, two words dropped, then push+pop while full
    clear();
    tready = 0;
    for (int i = 0; i < TB; i++) begin
      if (i == 41) begin
        chk("t2 overflow set", overflow, 1);
        chk("t2 held tvalid", tvalid, 1);
        chk("t2 held tdata", tdata, 32'h03020100);
        err_clr = 1;
      end
      if (i == 43) tready = 1;
      send(8'(i), i == 0);
      if (i == 43) chk("t2 push on full with pop", overflow, 0);
    end
    idle(6);
    chk("t2 words", 64'(nw), 194);
    chk("t2 tlast count", 64'(nlast), 1);
    chk("t2 tile_count", tile_count, 2);
    // resync: sot arrives mid-tile
    clear();
    send(8'h10, 1);
    for (int i = 1; i < 6; i++) send(8'(8'h10 + i), 0);
    send(8'hAA, 1);
    send(8'hAB, 0); send(8'hAC, 0); send(8'hAD, 0);
    idle(4);
    chk("t3 resync_err", resync_err, 1);
    chk("t3 words", 64'(nw), 2);
    chk("t3 first word", first_d, 32'h13121110);
    chk("t3 lane0", last_d[7:0], 8'hAA);
    chk("t3 resync word", last_d, 32'hADACABAA);
    err_clr = 1;
    tick();
    chk("t3 err_clr", resync_err, 0);
    // reset mid-word, then sot-less bytes are ignored
    send(8'h01, 0); send(8'h02, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t4 tvalid", tvalid, 0);
    chk("t4 tdata", tdata, 0);
    chk("t4 tkeep", tkeep, 0);
    chk("t4 tlast", tlast, 0);
    chk("t4 tile_count", tile_count, 0);
    chk("t4 resync_err", resync_err, 0);
    chk("t4 overflow", overflow, 0);
    clear();
    for (int i = 0; i < 8; i++) send(8'(8'h50 + i), 0);
    idle(4);
    chk("t4 ignored words", 64'(nw), 0);
    chk("t4 idle tvalid", tvalid, 0);
    // two back-to-back tiles
    clear();
    for (int i = 0; i < 2 * TB; i++) send(8'(i % TB), (i % TB) == 0);
    idle(6);
    chk("t5 words", 64'(nw), 392);
    chk("t5 tlast count", 64'(nlast), 2);
    chk("t5 tlast position", 64'(last_idx), 392);
    chk("t5 tile_count", tile_count, 2);
`ifdef TILE_STREAM_PACKER_TUSER_EN
    chk("t5 tuser count", 64'(uidx.size()), 2);
    if (uidx.size() == 2) begin
      chk("t5 tuser word a", 64'(uidx[0]), 1);
      chk("t5 tuser word b", 64'(uidx[1]), 197);
    end
`endif
    // 3x3 tile: last word partially filled
    q1.delete();
    for (int i = 0; i < 9; i++) send1(8'(8'h11 + i), i == 0);
    idle(5);
    chk("p words", 64'(q1.size()), 3);
    if (q1.size() == 3) begin
      chk("p word0", q1[0], {1'b0, 4'hF, 32'h14131211});
      chk("p word1", q1[1], {1'b0, 4'hF, 32'h18171615});
      chk("p word2", q1[2], {1'b1, 4'h1, 32'h00000019});
    end
    chk("p tile_count", t1cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_stream_packer.md
Name: tile_stream_packer

Overview:
- Captures 8-bit pixel bytes from the ADV7182A capture path and packs them little-endian into AXI4-Stream words: first byte goes in the LSB lane.
- Marks the final word of each TILE_W x TILE_H tile with tlast.
- Buffers words in a small FIFO so downstream back-pressure does not stall capture.
- Sits between the video decoder interface and the upscaler DMA/stream input.

Parameters:
- BYTES_PER_WORD, 4, byte lanes per output word; TDATA_W = 8*BYTES_PER_WORD; legal values 1, 2, 4, 8.
- TILE_W, 28, tile width in bytes.
- TILE_H, 28, tile height in lines; TILE_BYTES = TILE_W*TILE_H.
- FIFO_DEPTH, 8, output FIFO depth in words; power of two, >= 2.

Ports:
- aclk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- pix_data  in  8  pixel byte.
- pix_valid  in  1  pix_data valid this cycle; no back-pressure to the source.
- pix_sot  in  1  start of tile; qualified by pix_valid; marks the first byte of a tile.
- err_clr  in  1  single-cycle pulse; clears the sticky error flags.
- m_axis_tdata  out  TDATA_W  packed word.
- m_axis_tkeep  out  BYTES_PER_WORD  valid byte lanes.
- m_axis_tlast  out  1  last word of a tile.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- resync_err  out  1  sticky: pix_sot arrived mid-tile.
- tile_count  out  16  completed tiles; wraps at 0xFFFF -> 0.

Behaviour:
- Reset: every output is 0. FIFO is emptied, lane counter and byte counter are 0, FSM goes to IDLE. Reset takes effect on the next edge, mid-word or mid-tile, with no flush; partial data is discarded.
- FSM IDLE: bytes with pix_sot=0 are ignored. A byte with pix_valid & pix_sot loads lane 0 and moves the FSM to ACTIVE.
- FSM ACTIVE: each pix_valid byte goes to lane = lane_cnt. The byte counter increments modulo TILE_BYTES.
- Word completion: a word completes when lane_cnt == BYTES_PER_WORD-1 or the byte is tile byte TILE_BYTES-1.
- On completion the word, tkeep and tlast are pushed into the FIFO at the same edge, and lane_cnt returns to 0.
  - tkeep has ones for filled lanes only; unfilled lanes are zero-padded (TILE_BYTES not divisible by BYTES_PER_WORD).
  - tlast = 1 only for the word containing tile byte TILE_BYTES-1.
- Tile end: the FSM returns to IDLE and tile_count increments.
- Latency: the word's final byte is sampled at edge N; m_axis_tvalid is high after edge N+1 (registered FIFO output). Minimum byte-to-valid latency is 2 cycles.
- Mid-tile pix_sot: the partial word and byte count are discarded. resync_err is set and a new tile starts with this byte in lane 0. Words already in the FIFO are kept; no tlast is emitted for the truncated tile.
- FIFO full at completion: the word is dropped and overflow is set. Counters advance as normal, so tile alignment is preserved.
- Simultaneous push and pop on a full FIFO: the pop frees a slot and the push succeeds, with no overflow.
- AXIS: tdata, tkeep and tlast are held stable while tvalid & !tready. Pop happens on tvalid & tready. tvalid never depends combinationally on tready.
- err_clr clears both sticky flags. If an error event occurs in the same cycle, set has priority.

Optional Feature:
- Macro: TILE_STREAM_PACKER_TUSER_EN.
- Defined: adds port m_axis_tuser (out, 1). tuser = 1 on the first word of each tile, carried through the FIFO with its word; zero on all other words.
- Undefined: the port and the extra FIFO bit do not exist; all other behaviour is identical.

Decomposition:
- Shared package tile_stream_pkg: FSM state typedef (IDLE, ACTIVE); localparams TDATA_W and TILE_BYTES; a clog2-based width helper for the counters.
- One sub-module: sync_fifo (registered-output FIFO, parametrised width and depth, full/empty, simultaneous push/pop). The packer instantiates it with width TDATA_W + BYTES_PER_WORD + 1 (+1 with TUSER).

Test Plan:
- Tile streaming, default params, tready=1: sot plus bytes 0x00..0xFF cyclic (784 bytes) -> 196 words, first 0x03020100; tkeep=0xF on all words; tlast only on word 196; tile_count=1.
- Partial last word, TILE_W=3, TILE_H=3: 9 bytes 0x11..0x19 -> words 0x14131211, 0x18171615, then 0x00000019 with tkeep=0x1 and tlast=1.
- Back-pressure: tready=0 for 40 cycles while streaming -> 8 words held stable; further completions set overflow=1; after tready=1, tile_count still reaches 1 at tile end.
- Resync: sot, 6 bytes, then sot with 0xAA -> resync_err=1; the next emitted word's lane 0 = 0xAA; err_clr pulse -> resync_err=0.
- Reset mid-word: 2 bytes, then reset for 1 cycle -> tvalid=0 and all outputs 0. Bytes without sot are then ignored until the next sot.
- With TILE_STREAM_PACKER_TUSER_EN: two consecutive tiles -> tuser=1 exactly on word 1 and word 197.
